// File: rtl/matmul_mem_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_mem_arb_if
//  Description : Signal bundle for the matmul memory arbiter. It carries the
//                engine port, the host load/unload port and the SRAM port.
//  Revision    : 1.0  initial release
// ============================================================================
interface matmul_mem_arb_if #(
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32
);
  // engine port
  logic              eng_req;
  logic              eng_write;
  logic [MEM_AW-1:0] eng_addr;
  logic [MEM_DW-1:0] eng_wdata;
  logic              eng_rdata_vld;
  logic [MEM_DW-1:0] eng_rdata;
  // host port
  logic              host_req;
  logic              host_write;
  logic [MEM_AW-1:0] host_addr;
  logic [MEM_DW-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rdata_vld;
  logic [MEM_DW-1:0] host_rdata;
  logic              host_starved;
  // SRAM port
  logic              sram_en;
  logic              sram_we;
  logic [MEM_AW-1:0] sram_addr;
  logic [MEM_DW-1:0] sram_wdata;
  logic [MEM_DW-1:0] sram_rdata;

  // arbiter side
  modport slave (
    input  eng_req, eng_write, eng_addr, eng_wdata,
    output eng_rdata_vld, eng_rdata,
    input  host_req, host_write, host_addr, host_wdata,
    output host_gnt, host_rdata_vld, host_rdata, host_starved,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  // requester / memory side
  modport master (
    output eng_req, eng_write, eng_addr, eng_wdata,
    input  eng_rdata_vld, eng_rdata,
    output host_req, host_write, host_addr, host_wdata,
    input  host_gnt, host_rdata_vld, host_rdata, host_starved,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface
`default_nettype wire

// File: rtl/matmul_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_mem_arb
//  Description : Merges the non-stallable matmul engine memory port with a
//                req/gnt host port onto one single-port synchronous SRAM.
//                The engine always wins; read data is steered back to the
//                issuing port by a tag that travels alongside the SRAM read.
//  Revision    : 1.0  initial release
// ============================================================================
module matmul_mem_arb #(
  parameter int MEM_AW     = 16,
  parameter int MEM_DW     = 32,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  matmul_mem_arb_if.slave  bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {
    H_IDLE = 1'b0,
    H_RD   = 1'b1
  } host_state_t;

  host_state_t       state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_next;
  logic              starved;

  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_wdata;

  // Tag stages cover the SRAM latency; the final vld flops add the issue stage,
  // so a read selected at t reports vld at t+1+READ_LAT.
  logic [READ_LAT-1:0] tag_vld;
  logic [READ_LAT-1:0] tag_host;
  logic                eng_vld;
  logic                host_vld;

  logic gnt;
  logic rd_issue;

  // Host may only be accepted when the engine is silent and no host read is open.
  assign gnt      = bus.host_req & ~bus.eng_req & (state == H_IDLE);
  assign rd_issue = (bus.eng_req & ~bus.eng_write) | (gnt & ~bus.host_write);

  // Starvation counter next value: clears on grant or request drop, saturates.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (!bus.host_req || gnt) begin
      wait_cnt_next = '0;
    end else if (state == H_IDLE && wait_cnt != CNT_W'(STARVE_MAX)) begin
      wait_cnt_next = wait_cnt + 1'b1;
    end
  end

  // Register the selected access onto the SRAM port; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (bus.eng_req) begin
      mem_en    <= 1'b1;
      mem_we    <= bus.eng_write;
      mem_addr  <= bus.eng_addr;
      mem_wdata <= bus.eng_wdata;
    end else if (gnt) begin
      mem_en    <= 1'b1;
      mem_we    <= bus.host_write;
      mem_addr  <= bus.host_addr;
      mem_wdata <= bus.host_wdata;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // Shift the {vld, owner} read tag in step with the SRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld  <= '0;
      tag_host <= '0;
      eng_vld  <= 1'b0;
      host_vld <= 1'b0;
    end else begin
      tag_vld[0]  <= rd_issue;
      tag_host[0] <= ~bus.eng_req;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_host[i] <= tag_host[i-1];
      end
      eng_vld  <= tag_vld[READ_LAT-1] & ~tag_host[READ_LAT-1];
      host_vld <= tag_vld[READ_LAT-1] &  tag_host[READ_LAT-1];
    end
  end

  // Host FSM tracking the single outstanding host read, plus starvation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= H_IDLE;
      wait_cnt <= '0;
      starved  <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_next;
      starved  <= (wait_cnt_next == CNT_W'(STARVE_MAX));
      case (state)
        H_IDLE:  if (gnt && !bus.host_write) state <= H_RD;
        H_RD:    if (host_vld) state <= H_IDLE;
        default: state <= H_IDLE;
      endcase
    end
  end

  assign bus.host_gnt       = gnt;
  assign bus.sram_en        = mem_en;
  assign bus.sram_we        = mem_we;
  assign bus.sram_addr      = mem_addr;
  assign bus.sram_wdata     = mem_wdata;
  assign bus.eng_rdata_vld  = eng_vld;
  assign bus.host_rdata_vld = host_vld;
  assign bus.eng_rdata      = bus.sram_rdata;
  assign bus.host_rdata     = bus.sram_rdata;
  assign bus.host_starved   = starved;

endmodule
`default_nettype wire

// File: tb/tb_matmul_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matmul_mem_arb
//  Description : Directed and randomized bench for matmul_mem_arb against a
//                transaction-level reference of the arbitration rules, with
//                a behavioural single-port SRAM (read latency 1).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_matmul_mem_arb;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int SMAX = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matmul_mem_arb_if #(.MEM_AW(AW), .MEM_DW(DW)) bus ();

  matmul_mem_arb #(.MEM_AW(AW), .MEM_DW(DW), .READ_LAT(1), .STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] sram_mem [0:65535];
  logic [DW-1:0] ref_mem  [0:65535];

  // behavioural SRAM, one-cycle read latency
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we) sram_mem[bus.sram_addr] <= bus.sram_wdata;
      else             bus.sram_rdata <= sram_mem[bus.sram_addr];
    end
  end

  typedef struct {
    int            due;
    logic          host;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          pend[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc_n  = 0;
  int            host_free_at = 0;
  int            waited = 0;
  logic          e_en, e_we, e_starved;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          gnt_now;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic host, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    ret_t r;
    e_en = 1'b1; e_we = we; e_addr = a; e_wdata = d;
    if (we) ref_mem[a] = d;
    else begin
      r.due = cyc_n + 2; r.host = host; r.data = ref_mem[a];
      pend.push_back(r);
    end
  endtask

  // One clock cycle: check grant, advance the reference, check registered outputs.
  task automatic cyc();
    logic g, idle, ev, hv;
    logic [DW-1:0] ed;
    #1;
    idle = (cyc_n >= host_free_at);
    g = bus.host_req & ~bus.eng_req & idle;
    if (!rst) chk("host_gnt", bus.host_gnt, g);
    gnt_now = g & ~rst;
    if (rst) begin
      pend.delete();
      host_free_at = 0; waited = 0;
      e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_starved = 0;
    end else begin
      if (bus.eng_req) issue(1'b0, bus.eng_write, bus.eng_addr, bus.eng_wdata);
      else if (g) begin
        issue(1'b1, bus.host_write, bus.host_addr, bus.host_wdata);
        if (!bus.host_write) host_free_at = cyc_n + 3;
      end else begin
        e_en = 0; e_we = 0;
      end
      if (!bus.host_req || g) waited = 0;
      else if (idle && waited < SMAX) waited++;
      e_starved = (waited == SMAX);
    end
    @(posedge clk);
    #1;
    cyc_n++;
    chk("sram_en", bus.sram_en, e_en);
    chk("sram_we", bus.sram_we, e_we);
    chk("sram_addr", bus.sram_addr, e_addr);
    chk("sram_wdata", bus.sram_wdata, e_wdata);
    chk("host_starved", bus.host_starved, e_starved);
    ev = 0; hv = 0; ed = '0;
    if (pend.size() > 0 && pend[0].due == cyc_n) begin
      ev = ~pend[0].host; hv = pend[0].host; ed = pend[0].data;
      void'(pend.pop_front());
    end
    chk("eng_rdata_vld", bus.eng_rdata_vld, ev);
    chk("host_rdata_vld", bus.host_rdata_vld, hv);
    if (ev) chk("eng_rdata", bus.eng_rdata, ed);
    if (hv) chk("host_rdata", bus.host_rdata, ed);
  endtask

  task automatic eng(input logic req, input logic we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    bus.eng_req = req; bus.eng_write = we; bus.eng_addr = a; bus.eng_wdata = d;
  endtask

  task automatic host(input logic req, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    bus.host_req = req; bus.host_write = we; bus.host_addr = a; bus.host_wdata = d;
  endtask

  initial begin
    int k, n, first;
    logic [DW-1:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = $urandom;
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    sram_mem[16'h0010] = 32'hDEADBEEF;
    ref_mem[16'h0010]  = 32'hDEADBEEF;
    rst = 1'b1;
    eng(0, 0, '0, '0);
    host(0, 0, '0, '0);
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // 1: single engine read
    eng(1, 0, 16'h0010, '0); cyc();
    eng(0, 0, '0, '0);       cyc();
    chk("t1_eng_vld", bus.eng_rdata_vld, 1'b1);
    chk("t1_eng_data", bus.eng_rdata, 32'hDEADBEEF);
    chk("t1_host_vld", bus.host_rdata_vld, 1'b0);
    repeat (2) cyc();

    // 2: engine streaming reads
    n = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) eng(1, 0, AW'(i), '0); else eng(0, 0, '0, '0);
      cyc();
      if (bus.eng_rdata_vld) n++;
    end
    chk("t2_vld_count", n, 8);

    // 3: host write held against three engine pulses
    host(1, 1, 16'h0100, 32'h12345678);
    k = 0;
    while (k < 20) begin
      if (k < 3) eng(1, 0, AW'($urandom_range(0, 15)), '0); else eng(0, 0, '0, '0);
      cyc();
      if (gnt_now) break;
      k++;
    end
    chk("t3_gnt_cycle", k, 3);
    host(0, 0, '0, '0);
    cyc();

    // 4: host read round trip with a second request held behind it
    host(1, 0, 16'h0100, '0);
    cyc();
    chk("t4_first_gnt", gnt_now, 1'b1);
    host(1, 0, 16'h0020, '0);
    k = 0;
    while (k < 10) begin
      cyc();
      k++;
      if (k == 1) begin
        chk("t4_host_vld", bus.host_rdata_vld, 1'b1);
        chk("t4_host_data", bus.host_rdata, 32'h12345678);
      end
      if (gnt_now) break;
    end
    chk("t4_regnt_gap", k, 3);
    host(0, 0, '0, '0);
    repeat (3) cyc();

    // 5: starvation under continuous engine traffic
    host(1, 1, 16'h0200, 32'hCAFEF00D);
    first = -1;
    for (int j = 0; j < 20; j++) begin
      eng(1, $urandom_range(0, 1), AW'($urandom_range(0, 15)), $urandom);
      cyc();
      if (bus.host_starved && first < 0) first = j;
    end
    chk("t5_starve_rise", first, 14);
    eng(0, 0, '0, '0);
    cyc();
    chk("t5_gnt", gnt_now, 1'b1);
    host(0, 0, '0, '0);
    chk("t5_starve_clear", bus.host_starved, 1'b0);
    repeat (2) cyc();

    // 6: reset while an engine read is in flight
    eng(1, 0, 16'h0005, '0); cyc();
    eng(0, 0, '0, '0);
    rst = 1'b1; cyc();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (bus.eng_rdata_vld) n++;
    end
    chk("t6_no_vld", n, 0);

    // randomized mixed traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1)
        eng(1, $urandom_range(0, 1),
            $urandom_range(0, 1) ? AW'($urandom_range(0, 15)) : AW'(16'h0100 + $urandom_range(0, 15)),
            $urandom);
      else
        eng(0, 0, '0, '0);
      if (!bus.host_req && $urandom_range(0, 2) == 0)
        host(1, $urandom_range(0, 1), AW'($urandom_range(0, 15)), $urandom);
      cyc();
      if (gnt_now) begin
        if ($urandom_range(0, 1) == 1) host(0, 0, '0, '0);
        else host(1, $urandom_range(0, 1), AW'(16'h0100 + $urandom_range(0, 15)), $urandom);
      end
    end
    eng(0, 0, '0, '0);
    host(0, 0, '0, '0);
    repeat (4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
